// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one trial subtraction per clock.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request a division; accepted only on an edge where busy is low
//   a      - dividend (w bits, unsigned), sampled on the accepting edge
//   b      - divisor  (w bits, unsigned), sampled on the accepting edge
//   busy   - division in progress
//   done   - one-cycle pulse; q, r and dbz are valid
//   q      - quotient (all ones on divide-by-zero)
//   r      - remainder (dividend on divide-by-zero)
//   dbz    - last accepted divisor was zero
//
// q, r and dbz are only written when a division completes, so they hold the
// previous result throughout a following RUN phase.

module seq_divider #(
  parameter int unsigned w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] q,
  output logic [w-1:0] r,
  output logic         dbz
);

  localparam int unsigned CntW = (w > 2) ? $clog2(w) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(w - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [w-1:0]    dvd_q;   // dividend bits shift out the top, quotient bits shift in
  logic [w-1:0]    b_q;
  logic [w-1:0]    rem_q;   // partial remainder stays below b, so w bits hold it
  logic [CntW-1:0] cnt_q;

  logic [w:0]      shift;
  logic [w:0]      diff;
  logic            q_bit;
  logic [w-1:0]    rem_next;
  logic [w-1:0]    dvd_next;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  always_comb begin
    shift    = {rem_q, dvd_q[w-1]};
    diff     = shift - {1'b0, b_q};
    q_bit    = ~diff[w];
    rem_next = q_bit ? diff[w-1:0] : shift[w-1:0];
    dvd_next = {dvd_q[w-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            dvd_q <= a;
            b_q   <= b;
            rem_q <= '0;
            cnt_q <= '0;
            if (b == '0) begin
              // Divide-by-zero resolves immediately without entering RUN.
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              q       <= '1;
              r       <= a;
              dbz     <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end

        StRun: begin
          dvd_q <= dvd_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            q       <= dvd_next;
            r       <= rem_next;
            dbz     <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  int checks;
  int errors;
  int busy_cycles;
  int done_seen;

  seq_divider #(.w(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle monitor on the inactive edge: busy/done exclusivity and event counts.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(busy && done)) else begin
        errors++;
        $error("FAIL busy_done_overlap: observed busy=%0b done=%0b required not both high",
               busy, done);
      end
      if (busy) busy_cycles++;
      if (done) done_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Advances edge by edge (sampling #1 after each) until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  // Full transaction: start for one cycle, wait for done, check result and timing.
  task automatic run_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat, input int ebusy);
    int n;
    a           = av;
    b           = bv;
    start       = 1'b1;
    busy_cycles = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, n + 1, elat);
    check({tag, "_busy_cycles"}, busy_cycles, ebusy);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, edbz});
    @(posedge clk);
    #1;
    check({tag, "_done_drops"}, {31'd0, done}, 32'd0);
    check({tag, "_q_holds"}, q, eq);
  endtask

  initial begin
    int n;
    int done_before;
    checks      = 0;
    errors      = 0;
    busy_cycles = 0;
    done_seen   = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    a           = '0;
    b           = '0;

    // Reset state
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_dbz", {31'd0, dbz}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic and boundary divisions
    run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W + 1, W);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W + 1, W);
    run_div("d5_10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0, W + 1, W);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, W + 1, W);

    // Divide by zero resolves in one cycle with busy never high
    run_div("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1, 0);
    run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W + 1, W);

    // start pulsed during RUN is ignored
    a           = 8'd200;
    b           = 8'd7;
    start       = 1'b1;
    busy_cycles = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a     = 8'd50;
    b     = 8'd5;
    start = 1'b1;
    check("ign_q_stable_in_run", q, 8'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("ign_latency", n + 4, W + 1);
    check("ign_q", q, 8'd28);
    check("ign_r", r, 8'd4);
    @(posedge clk);
    #1;
    check("ign_no_restart", {31'd0, busy}, 32'd0);

    // Back-to-back: start held through the done cycle
    a           = 8'd200;
    b           = 8'd7;
    start       = 1'b1;
    busy_cycles = 0;
    @(posedge clk);
    #1;
    a = 8'd81;
    b = 8'd9;
    wait_done(n);
    check("b2b_first_latency", n + 1, W + 1);
    check("b2b_first_q", q, 8'd28);
    check("b2b_first_r", r, 8'd4);
    busy_cycles = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
    check("b2b_old_q_visible", q, 8'd28);
    check("b2b_old_r_visible", r, 8'd4);
    wait_done(n);
    check("b2b_second_latency", n + 1, W + 1);
    check("b2b_second_busy_cycles", busy_cycles, W);
    check("b2b_second_q", q, 8'd9);
    check("b2b_second_r", r, 8'd0);

    // Asynchronous reset mid-RUN aborts with no done
    @(posedge clk);
    #1;
    a     = 8'd200;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    done_before = done_seen;
    rst_n       = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    check("arst_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_done", done_seen, done_before);
    check("arst_idle_busy", {31'd0, busy}, 32'd0);
    run_div("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, W + 1, W);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
